// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/bubble sequencer for the T/D/E/M/W pipeline registers.
//   Resolves memory wait (highest priority), control redirect and load-use
//   hazards. Outputs are Mealy so a hazard acts in the cycle it is seen.
//   Optional feature macro: HAZARD_PERF_EN builds the stall/flush counters;
//   without it both counter outputs are tied to 0.
//   Handshake note: there is no valid/ready pair here; every control output
//   is a level that the register banks sample at the next rising clk edge.
//   dbg_state exposes the FSM state (0 RUN, 1 LU_WAIT, 2 REDIR).
module pipeline_hazard_ctrl #(
    parameter int LOAD_LAT        = 2,
    parameter int REDIRECT_SHADOW = 1,
    parameter int PERF_W          = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [4:0]        d_ra,
    input  logic [4:0]        d_rb,
    input  logic              d_need_ra,
    input  logic              d_need_rb,
    input  logic [4:0]        e_rn,
    input  logic [4:0]        m_rn,
    input  logic              e_wreg,
    input  logic              e_m2reg,
    input  logic              m_wreg,
    input  logic              m_m2reg,
    input  logic              m_mem_busy,
    input  logic              e_redirect,
    output logic              t_stall,
    output logic              t_bubble,
    output logic              d_stall,
    output logic              d_bubble,
    output logic              e_stall,
    output logic              e_bubble,
    output logic              m_stall,
    output logic              m_bubble,
    output logic              w_bubble,
    output logic              pc_stall,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_WAIT = 2'd1,
        REDIR   = 2'd2
    } state_t;

    // Remaining hazard cycles after the detection cycle; saturate at 0.
    localparam logic [2:0] LU_CNT_E   = (LOAD_LAT >= 1) ? 3'(LOAD_LAT - 1) : 3'd0;
    localparam logic [2:0] LU_CNT_M   = (LOAD_LAT >= 2) ? 3'(LOAD_LAT - 2) : 3'd0;
    localparam logic [2:0] SHADOW_CNT = 3'(REDIRECT_SHADOW);

    state_t     state;
    state_t     state_n;
    logic [2:0] cnt;
    logic [2:0] cnt_n;
    logic       dep_e;
    logic       dep_m;

    // Load-use operand match of the D instruction against loads in E and M.
    always_comb begin
        dep_e = (d_need_ra && (d_ra != 5'd0) && e_wreg && e_m2reg && (e_rn == d_ra)) ||
                (d_need_rb && (d_rb != 5'd0) && e_wreg && e_m2reg && (e_rn == d_rb));
        dep_m = (d_need_ra && (d_ra != 5'd0) && m_wreg && m_m2reg && (m_rn == d_ra)) ||
                (d_need_rb && (d_rb != 5'd0) && m_wreg && m_m2reg && (m_rn == d_rb));
    end

    // State and countdown register; reset drops any pending hazard.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: memory wait freezes everything, then redirect, then load-use.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!m_mem_busy) begin
            if (e_redirect) begin
                if (SHADOW_CNT != 3'd0) begin
                    state_n = REDIR;
                    cnt_n   = SHADOW_CNT;
                end else begin
                    state_n = RUN;
                    cnt_n   = 3'd0;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (dep_e) begin
                            cnt_n   = LU_CNT_E;
                            state_n = (LU_CNT_E != 3'd0) ? LU_WAIT : RUN;
                        end else if (dep_m) begin
                            cnt_n   = LU_CNT_M;
                            state_n = (LU_CNT_M != 3'd0) ? LU_WAIT : RUN;
                        end
                    end
                    LU_WAIT, REDIR: begin
                        if (cnt <= 3'd1) begin
                            cnt_n   = 3'd0;
                            state_n = RUN;
                        end else begin
                            cnt_n = cnt - 3'd1;
                        end
                    end
                    default: begin
                        state_n = RUN;
                        cnt_n   = 3'd0;
                    end
                endcase
            end
        end
    end

    // Mealy outputs; forced low while reset is asserted.
    always_comb begin
        t_stall  = 1'b0;
        t_bubble = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        e_stall  = 1'b0;
        e_bubble = 1'b0;
        m_stall  = 1'b0;
        m_bubble = 1'b0;
        w_bubble = 1'b0;
        pc_stall = 1'b0;
        if (resetn) begin
            if (m_mem_busy) begin
                t_stall  = 1'b1;
                d_stall  = 1'b1;
                e_stall  = 1'b1;
                m_stall  = 1'b1;
                pc_stall = 1'b1;
                w_bubble = 1'b1;
            end else if (e_redirect) begin
                t_bubble = 1'b1;
                d_bubble = 1'b1;
                e_bubble = 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (dep_e || dep_m) begin
                            pc_stall = 1'b1;
                            t_stall  = 1'b1;
                            d_stall  = 1'b1;
                            e_bubble = 1'b1;
                        end
                    end
                    LU_WAIT: begin
                        pc_stall = 1'b1;
                        t_stall  = 1'b1;
                        d_stall  = 1'b1;
                        e_bubble = 1'b1;
                    end
                    REDIR: begin
                        t_bubble = 1'b1;
                    end
                    default: begin
                        t_bubble = 1'b0;
                    end
                endcase
            end
        end
    end

    assign dbg_state = state;

`ifdef HAZARD_PERF_EN
    // Stall and flush cycle counters; wrap naturally at 2^PERF_W.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_stall) perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (t_bubble) perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (LOAD_LAT=2, REDIRECT_SHADOW=1).
module tb_pipeline_hazard_ctrl;

    // Output bit order: {pc,t_st,t_bu,d_st,d_bu,e_st,e_bu,m_st,m_bu,w_bu}
    localparam logic [9:0] NO = 10'b0000000000;
    localparam logic [9:0] LU = 10'b1101001000;
    localparam logic [9:0] RD = 10'b0010101000;
    localparam logic [9:0] RS = 10'b0010000000;
    localparam logic [9:0] MW = 10'b1101010101;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LUW = 2'd1;
    localparam logic [1:0] S_RDR = 2'd2;

    typedef struct {
        logic [4:0] d_ra, d_rb, e_rn, m_rn;
        logic [1:0] need;   // {need_ra, need_rb}
        logic [1:0] e_wm;   // {wreg, m2reg}
        logic [1:0] m_wm;
        logic       busy, redir;
        logic [9:0] exp;
        logic [1:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [4:0] d_ra = '0, d_rb = '0, e_rn = '0, m_rn = '0;
    logic d_need_ra = 0, d_need_rb = 0, e_wreg = 0, e_m2reg = 0, m_wreg = 0, m_m2reg = 0;
    logic m_mem_busy = 0, e_redirect = 0;
    logic t_stall, t_bubble, d_stall, d_bubble, e_stall, e_bubble, m_stall, m_bubble, w_bubble, pc_stall;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic [1:0] dbg_state;
    logic [9:0] outs;

    int checks = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic [9:0] exp_q[$];
    logic [1:0] st_q[$];
    vec_t vecs[38];

    assign outs = {pc_stall, t_stall, t_bubble, d_stall, d_bubble, e_stall, e_bubble, m_stall, m_bubble, w_bubble};

    pipeline_hazard_ctrl #(.LOAD_LAT(2), .REDIRECT_SHADOW(1), .PERF_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .d_ra(d_ra), .d_rb(d_rb), .d_need_ra(d_need_ra), .d_need_rb(d_need_rb),
        .e_rn(e_rn), .m_rn(m_rn), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
        .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_mem_busy(m_mem_busy), .e_redirect(e_redirect),
        .t_stall(t_stall), .t_bubble(t_bubble), .d_stall(d_stall), .d_bubble(d_bubble),
        .e_stall(e_stall), .e_bubble(e_bubble), .m_stall(m_stall), .m_bubble(m_bubble),
        .w_bubble(w_bubble), .pc_stall(pc_stall),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] ra, input logic [4:0] rb, input logic [1:0] need,
                                input logic [4:0] ern, input logic [1:0] ewm,
                                input logic [4:0] mrn, input logic [1:0] mwm,
                                input logic busy, input logic redir,
                                input logic [9:0] exp, input logic [1:0] st);
        vec_t v;
        v.d_ra = ra; v.d_rb = rb; v.need = need; v.e_rn = ern; v.e_wm = ewm;
        v.m_rn = mrn; v.m_wm = mwm; v.busy = busy; v.redir = redir; v.exp = exp; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        d_ra = v.d_ra; d_rb = v.d_rb; {d_need_ra, d_need_rb} = v.need;
        e_rn = v.e_rn; {e_wreg, e_m2reg} = v.e_wm;
        m_rn = v.m_rn; {m_wreg, m_m2reg} = v.m_wm;
        m_mem_busy = v.busy; e_redirect = v.redir;
    endtask

    // Driver: called just after a rising edge; checks at the falling edge.
    task automatic drive(input vec_t v, input string name);
        logic [9:0] e_out;
        logic [1:0] e_st;
        set_inputs(v);
        exp_q.push_back(v.exp);
        st_q.push_back(v.st);
        if (v.exp[9]) exp_stall++;
        if (v.exp[7]) exp_flush++;
        @(negedge clk);
        e_out = exp_q.pop_front();
        e_st = st_q.pop_front();
        check({name, "_outs"}, 32'(outs), 32'(e_out));
        check({name, "_state"}, 32'(dbg_state), 32'(e_st));
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_dep_m(input vec_t v);
        return (v.need[1] && v.d_ra != 0 && v.m_wm == 2'b11 && v.m_rn == v.d_ra) ||
               (v.need[0] && v.d_rb != 0 && v.m_wm == 2'b11 && v.m_rn == v.d_rb);
    endfunction

    initial begin
        vec_t rv;
        vecs[0]  = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);
        vecs[1]  = mk(5,0,2'b10, 5,2'b11, 0,2'b00, 0,0, LU,S_RUN);
        vecs[2]  = mk(5,0,2'b10, 0,2'b00, 5,2'b11, 0,0, LU,S_LUW);
        vecs[3]  = mk(5,0,2'b10, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);
        vecs[4]  = mk(0,0,2'b10, 0,2'b11, 0,2'b00, 0,0, NO,S_RUN);
        vecs[5]  = mk(5,0,2'b00, 5,2'b11, 0,2'b00, 0,0, NO,S_RUN);
        vecs[6]  = mk(0,7,2'b01, 7,2'b11, 0,2'b00, 0,0, LU,S_RUN);
        vecs[7]  = mk(0,7,2'b01, 0,2'b00, 7,2'b11, 0,0, LU,S_LUW);
        vecs[8]  = mk(0,7,2'b01, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);
        vecs[9]  = mk(3,0,2'b10, 3,2'b11, 0,2'b00, 0,0, LU,S_RUN);
        vecs[10] = mk(3,0,2'b10, 0,2'b00, 3,2'b11, 1,0, MW,S_LUW);
        vecs[11] = mk(3,0,2'b10, 0,2'b00, 3,2'b11, 1,0, MW,S_LUW);
        vecs[12] = mk(3,0,2'b10, 0,2'b00, 3,2'b11, 1,0, MW,S_LUW);
        vecs[13] = mk(3,0,2'b10, 0,2'b00, 3,2'b11, 0,0, LU,S_LUW);
        vecs[14] = mk(3,0,2'b10, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);
        vecs[15] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 1,1, MW,S_RUN);
        vecs[16] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 1,1, MW,S_RUN);
        vecs[17] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,1, RD,S_RUN);
        vecs[18] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,0, RS,S_RDR);
        vecs[19] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);
        vecs[20] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,1, RD,S_RUN);
        vecs[21] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,1, RD,S_RDR);
        vecs[22] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,0, RS,S_RDR);
        vecs[23] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);
        vecs[24] = mk(5,0,2'b10, 5,2'b11, 0,2'b00, 0,1, RD,S_RUN);
        vecs[25] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,0, RS,S_RDR);
        vecs[26] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);
        vecs[27] = mk(9,0,2'b10, 0,2'b00, 9,2'b11, 0,0, LU,S_RUN);
        vecs[28] = mk(9,0,2'b10, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);
        vecs[29] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,1, RD,S_RUN);
        vecs[30] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 1,0, MW,S_RDR);
        vecs[31] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,0, RS,S_RDR);
        vecs[32] = mk(0,0,2'b00, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);
        vecs[33] = mk(5,0,2'b10, 5,2'b10, 0,2'b00, 0,0, NO,S_RUN);
        vecs[34] = mk(5,0,2'b10, 0,2'b00, 5,2'b10, 0,0, NO,S_RUN);
        vecs[35] = mk(4,6,2'b11, 4,2'b11, 6,2'b11, 0,0, LU,S_RUN);
        vecs[36] = mk(4,6,2'b11, 0,2'b00, 4,2'b11, 0,0, LU,S_LUW);
        vecs[37] = mk(4,6,2'b11, 0,2'b00, 0,2'b00, 0,0, NO,S_RUN);

        // Reset block: outputs must stay low even with hazards presented.
        m_mem_busy = 1'b1;
        e_redirect = 1'b1;
        #3;
        check("reset_outs", 32'(outs), 32'(NO));
        check("reset_state", 32'(dbg_state), 32'(S_RUN));
        check("reset_perf_stall", perf_stall_cnt, 32'd0);
        check("reset_perf_flush", perf_flush_cnt, 32'd0);
        m_mem_busy = 1'b0;
        e_redirect = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 38; i++) drive(vecs[i], $sformatf("vec%0d", i));

        // Random single-cycle patterns: load only in M, never leaves RUN.
        for (int i = 0; i < 40; i++) begin
            rv.d_ra = 5'($urandom_range(0, 3));
            rv.d_rb = 5'($urandom_range(0, 3));
            rv.e_rn = 5'($urandom_range(0, 3));
            rv.m_rn = 5'($urandom_range(0, 3));
            rv.need = 2'($urandom_range(0, 3));
            rv.e_wm = {1'($urandom_range(0, 1)), 1'b0};
            rv.m_wm = 2'($urandom_range(0, 3));
            rv.busy = 1'b0;
            rv.redir = 1'b0;
            rv.exp = model_dep_m(rv) ? LU : NO;
            rv.st = S_RUN;
            drive(rv, $sformatf("rand%0d", i));
        end

`ifdef HAZARD_PERF_EN
        check("perf_stall", perf_stall_cnt, 32'(exp_stall));
        check("perf_flush", perf_flush_cnt, 32'(exp_flush));
`else
        check("perf_stall_off", perf_stall_cnt, 32'd0);
        check("perf_flush_off", perf_flush_cnt, 32'd0);
`endif

        // Asynchronous reset in the middle of a load-use wait.
        drive(vecs[1], "pre_rst");
        set_inputs(vecs[10]);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_outs", 32'(outs), 32'(NO));
        check("midrst_state", 32'(dbg_state), 32'(S_RUN));
        check("midrst_perf_stall", perf_stall_cnt, 32'd0);
        check("midrst_perf_flush", perf_flush_cnt, 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        set_inputs(vecs[0]);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        drive(vecs[3], "post_rst_idle");
        drive(vecs[27], "post_rst_dep_m");
        drive(vecs[29], "post_rst_redir");
        drive(vecs[31], "post_rst_shadow");
`ifdef HAZARD_PERF_EN
        check("post_perf_stall", perf_stall_cnt, 32'(exp_stall));
        check("post_perf_flush", perf_flush_cnt, 32'(exp_flush));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
